// File: rtl/memory_stage.sv
// Memory-access stage of the RV64 pipeline: issues loads/stores on the data bus,
// extracts and extends load data, flags misaligned accesses, holds the M/W register.
package memory_stage_pkg;
  typedef enum logic [4:0] {
    NOP, ADD, SUB, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  } decoded_op_t;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef enum logic [2:0] {
    NOERROR, INSTR_MISALIGN, ILLEGAL_INSTR, LOAD_MISALIGN, STORE_MISALIGN
  } error_t;

  typedef struct packed {
    decoded_op_t op;
    logic        regwrite;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] rd2;
    error_t      error;
  } excute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] addr;
    logic [63:0] result;
    error_t      error;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t dataE,
  input  logic         flush,
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp,
  output memory_data_t dataM,
  output logic         stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t       state_reg, state_next;
  dbus_req_t    req_reg;
  memory_data_t pend_reg;
  memory_data_t dataM_next;

  logic         is_load, is_store, misaligned, eligible;
  msize_t       size_e;
  dbus_req_t    req_e;
  memory_data_t base_e;
  logic         unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

  function automatic logic op_is_load(decoded_op_t op);
    return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
  endfunction

  function automatic logic [63:0] extend(decoded_op_t op, logic [63:0] bus, logic [2:0] off);
    logic [63:0] raw;
    raw = bus >> {off, 3'b000};
    case (op)
      LB:      extend = {{56{raw[7]}}, raw[7:0]};
      LH:      extend = {{48{raw[15]}}, raw[15:0]};
      LW:      extend = {{32{raw[31]}}, raw[31:0]};
      LBU:     extend = {56'b0, raw[7:0]};
      LHU:     extend = {48'b0, raw[15:0]};
      LWU:     extend = {32'b0, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

  // Decode of the instruction currently presented by execute
  always_comb begin
    is_load  = op_is_load(dataE.ctl.op);
    is_store = dataE.ctl.op inside {SB, SH, SW, SD};
    case (dataE.ctl.op)
      LB, LBU, SB: size_e = MSIZE1;
      LH, LHU, SH: size_e = MSIZE2;
      LW, LWU, SW: size_e = MSIZE4;
      default:     size_e = MSIZE8;
    endcase
    case (size_e)
      MSIZE2:  misaligned = dataE.result[0];
      MSIZE4:  misaligned = |dataE.result[1:0];
      MSIZE8:  misaligned = |dataE.result[2:0];
      default: misaligned = 1'b0;
    endcase
    eligible = ~reset && dataE.valid && (is_load || is_store) && ~misaligned
               && (dataE.error == NOERROR) && ~flush;

    req_e        = '0;
    req_e.valid  = 1'b1;
    req_e.addr   = dataE.result;
    req_e.size   = size_e;
    req_e.data   = dataE.rd2 << {dataE.result[2:0], 3'b000};
    if (is_store) begin
      case (size_e)
        MSIZE1:  req_e.strobe = 8'h01 << dataE.result[2:0];
        MSIZE2:  req_e.strobe = 8'h03 << dataE.result[2:0];
        MSIZE4:  req_e.strobe = 8'h0f << dataE.result[2:0];
        default: req_e.strobe = 8'hff;
      endcase
    end

    base_e        = '0;
    base_e.valid  = dataE.valid;
    base_e.pc     = dataE.pc;
    base_e.ctl    = dataE.ctl;
    base_e.dst    = dataE.dst;
    base_e.addr   = dataE.result;
    base_e.result = dataE.result;
    base_e.error  = dataE.error;
    // Misaligned accesses retire as exceptions that must not write a register
    if (dataE.valid && (is_load || is_store) && (dataE.error == NOERROR) && misaligned) begin
      base_e.error        = is_load ? LOAD_MISALIGN : STORE_MISALIGN;
      base_e.dst          = '0;
      base_e.ctl.regwrite = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    dreq       = '0;
    stall      = 1'b0;
    dataM_next = '0;
    case (state_reg)
      IDLE: begin
        if (eligible) begin
          dreq  = req_e;
          stall = ~dresp.data_ok;
          if (!dresp.data_ok) state_next = BUSY;
        end
        if (!stall && !flush) begin
          dataM_next = base_e;
          if (eligible && is_load)
            dataM_next.result = extend(dataE.ctl.op, dresp.data, dataE.result[2:0]);
        end
      end
      BUSY: begin
        dreq  = req_reg;
        stall = ~dresp.data_ok;
        if (dresp.data_ok) begin
          state_next = IDLE;
          if (!flush) begin
            dataM_next = pend_reg;
            if (op_is_load(pend_reg.ctl.op))
              dataM_next.result = extend(pend_reg.ctl.op, dresp.data, pend_reg.addr[2:0]);
          end
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Flushed access still owns the bus; its response is dropped
        dreq  = req_reg;
        stall = ~dresp.data_ok;
        if (dresp.data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      req_reg   <= '0;
      pend_reg  <= '0;
      dataM     <= '0;
    end else begin
      state_reg <= state_next;
      dataM     <= dataM_next;
      if (state_reg == IDLE && eligible) begin
        req_reg  <= req_e;
        pend_reg <= base_e;
      end
    end
  end

endmodule
